// File: rtl/cpu_inst_mem.sv
// Instruction-memory responder: serves fetch requests from an internal word
// array with a fixed read latency, accepts side-band program loads at any
// time, and raises a sticky fault on misaligned or out-of-range addresses.
module cpu_inst_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_mem_addr,
  output logic        o_mem_ready,
  output logic [31:0] o_mem_data,
  output logic        o_mem_valid,
  input  logic        i_load_en,
  input  logic [31:0] i_load_addr,
  input  logic [31:0] i_load_data,
  output logic        o_fault
);

  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [31:0] rdata_r, rdata_nxt_s;
  logic [31:0] data_r, data_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic        fault_r, fault_nxt_s;

  logic [31:0] mem_r [DEPTH_WORDS];

  logic          ready_s;
  logic          rd_fault_s;
  logic          ld_fault_s;
  logic [AW-1:0] rd_idx_s;
  logic [AW-1:0] ld_idx_s;
  logic [31:0]   rd_word_s;

  // An address is bad when it is not word aligned or sets any bit above the
  // word-index field (no aliasing into the array).
  function automatic logic addr_bad(input logic [31:0] addr);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ((addr >> (AW + 2)) != 32'd0);
    return misaligned | out_of_range;
  endfunction

  assign rd_idx_s   = i_mem_addr[AW+1:2];
  assign ld_idx_s   = i_load_addr[AW+1:2];
  assign rd_fault_s = addr_bad(i_mem_addr);
  assign ld_fault_s = addr_bad(i_load_addr);

  // Ready only in IDLE and never while a load is in progress, so a load and a
  // read can never hit the array in the same cycle.
  assign ready_s = (state_r == IDLE) && !i_load_en;

  assign o_mem_ready = ready_s;
  assign o_mem_data  = data_r;
  assign o_mem_valid = valid_r;
  assign o_fault     = fault_r;

  // Read word for the current fetch address; faulting reads return zero.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    if (rd_fault_s) begin
      rd_word_s = 32'h0000_0000;
    end else begin
      rd_word_s = mem_r[rd_idx_s];
    end
  end

  // Load-port write into the array; bad addresses are dropped.
  always_ff @(posedge i_clk) begin
    if (i_load_en && !ld_fault_s) begin
      mem_r[ld_idx_s] <= i_load_data;
    end
  end

  // Next-state, latency counter, read snapshot, output and fault logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    rdata_nxt_s = rdata_r;
    data_nxt_s  = data_r;
    valid_nxt_s = 1'b0;
    fault_nxt_s = fault_r;

    case (state_r)
      IDLE: begin
        if (ready_s) begin
          rdata_nxt_s = rd_word_s;
          if (LATENCY == 1) begin
            state_nxt_s = RESP;
            valid_nxt_s = 1'b1;
            data_nxt_s  = rd_word_s;
          end else begin
            state_nxt_s = BUSY;
            cnt_nxt_s   = LAT_M1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_nxt_s = RESP;
          valid_nxt_s = 1'b1;
          data_nxt_s  = rdata_r;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase

    if ((ready_s && rd_fault_s) || (i_load_en && ld_fault_s)) begin
      fault_nxt_s = 1'b1;
    end else begin
      fault_nxt_s = fault_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      rdata_r <= 32'h0000_0000;
      data_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      rdata_r <= rdata_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      fault_r <= fault_nxt_s;
    end
  end

endmodule

// File: tb/tb_cpu_inst_mem.sv
// Self-checking bench for cpu_inst_mem (DEPTH_WORDS=1024, LATENCY=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cpu_inst_mem;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        mem_valid;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        fault;

  int checks;
  int fails;
  int cyc;

  logic [31:0] exp_q[$];

  cpu_inst_mem #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_mem_addr (mem_addr),
    .o_mem_ready(mem_ready),
    .o_mem_data (mem_data),
    .o_mem_valid(mem_valid),
    .i_load_en  (load_en),
    .i_load_addr(load_addr),
    .i_load_data(load_data),
    .o_fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute cycle counter used to measure valid-pulse spacing.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Single load-port write; called at a falling edge, returns at the next one.
  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Present a fetch address, wait (bounded) for acceptance, then report the
  // returned word, latency, fault after the accept edge and the cycle after valid.
  task automatic issue_read(input logic [31:0] a, output logic [31:0] data,
                            output int lat, output int wait_c, output logic flt_a1,
                            output logic rdy_after, output logic v_after, output int vcyc);
    mem_addr  = a;
    data      = 32'hxxxx_xxxx;
    lat       = -1;
    wait_c    = 0;
    flt_a1    = 1'bx;
    rdy_after = 1'bx;
    v_after   = 1'bx;
    vcyc      = -1;
    #1;
    while (!mem_ready && wait_c < 20) begin
      @(negedge clk);
      #1;
      wait_c++;
    end
    if (!mem_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: addr=%h ready=%b expected 1", a, mem_ready);
      return;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) flt_a1 = fault;
      if (mem_valid) begin
        lat  = k;
        data = mem_data;
        vcyc = cyc;
        break;
      end
    end
    @(negedge clk);
    rdy_after = mem_ready;
    v_after   = mem_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", mem_ready); end
    checks++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", mem_valid); end
    checks++; if (mem_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", mem_data); end
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b expected 0", fault); end
  endtask

  task automatic test_first_read();
    logic [31:0] d; int lat; int w; logic f1; logic ra; logic va; int vc;
    logic [31:0] exp;
    load_word(32'h0, 32'h0000_0013);
    load_word(32'h4, 32'h0010_0093);
    load_word(32'h8, 32'h0020_0113);
    exp_q.push_back(32'h0000_0013);
    issue_read(32'h0, d, lat, w, f1, ra, va, vc);
    exp = exp_q.pop_front();
    checks++; if (w != 0) begin fails++; $display("FAIL first_accept_wait: got %0d expected 0", w); end
    checks++; if (lat != 2) begin fails++; $display("FAIL first_latency: got %0d expected 2", lat); end
    checks++; if (d !== exp) begin fails++; $display("FAIL first_data: got %h expected %h", d, exp); end
    checks++; if (va !== 1'b0) begin fails++; $display("FAIL first_valid_single: got %b expected 0", va); end
    checks++; if (ra !== 1'b1) begin fails++; $display("FAIL first_ready_again: got %b expected 1", ra); end
  endtask

  task automatic test_fetch_loop();
    logic [31:0] d; int lat; int w; logic f1; logic ra; logic va; int vc;
    logic [31:0] exp;
    logic [31:0] words [3];
    int prev_vc;
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    words[2] = 32'h0020_0113;
    prev_vc = -1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(words[i]);
      issue_read(32'(i * 4), d, lat, w, f1, ra, va, vc);
      exp = exp_q.pop_front();
      checks++; if (d !== exp) begin fails++; $display("FAIL loop_data[%0d]: got %h expected %h", i, d, exp); end
      checks++; if (w != 0) begin fails++; $display("FAIL loop_wait[%0d]: got %0d expected 0", i, w); end
      if (i > 0) begin
        checks++; if (vc - prev_vc != 3) begin fails++; $display("FAIL loop_spacing[%0d]: got %0d expected 3", i, vc - prev_vc); end
      end
      prev_vc = vc;
    end
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL loop_fault: got %b expected 0", fault); end
  endtask

  task automatic test_load_hold();
    logic [31:0] d; int lat; int w; logic f1; logic ra; logic va; int vc;
    logic [31:0] exp;
    load_en   = 1'b1;
    load_addr = 32'h100;
    load_data = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL hold_ready[%0d]: got %b expected 0", i, mem_ready); end
      checks++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL hold_valid[%0d]: got %b expected 0", i, mem_valid); end
      @(negedge clk);
    end
    load_en = 1'b0;
    exp_q.push_back(32'h0020_0113);
    issue_read(32'h8, d, lat, w, f1, ra, va, vc);
    exp = exp_q.pop_front();
    checks++; if (w != 0) begin fails++; $display("FAIL hold_first_accept: got wait %0d expected 0", w); end
    checks++; if (d !== exp) begin fails++; $display("FAIL hold_data: got %h expected %h", d, exp); end
  endtask

  task automatic test_busy_load();
    logic [31:0] d; int lat; int w; logic f1; logic ra; logic va; int vc;
    logic [31:0] exp;
    exp_q.push_back(32'h0010_0093);
    mem_addr = 32'h4;
    #1;
    checks++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL busy_accept_ready: got %b expected 1", mem_ready); end
    @(negedge clk);
    load_word(32'h4, 32'hDEAD_BEEF);
    exp = exp_q.pop_front();
    checks++; if (mem_valid !== 1'b1) begin fails++; $display("FAIL busy_valid: got %b expected 1", mem_valid); end
    checks++; if (mem_data !== exp) begin fails++; $display("FAIL busy_old_data: got %h expected %h", mem_data, exp); end
    @(negedge clk);
    exp_q.push_back(32'hDEAD_BEEF);
    issue_read(32'h4, d, lat, w, f1, ra, va, vc);
    exp = exp_q.pop_front();
    checks++; if (d !== exp) begin fails++; $display("FAIL busy_new_data: got %h expected %h", d, exp); end
  endtask

  task automatic test_fault();
    logic [31:0] d; int lat; int w; logic f1; logic ra; logic va; int vc;
    logic [31:0] exp;
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL fault_before: got %b expected 0", fault); end
    exp_q.push_back(32'h0);
    issue_read(32'h2, d, lat, w, f1, ra, va, vc);
    exp = exp_q.pop_front();
    checks++; if (d !== exp) begin fails++; $display("FAIL misaligned_data: got %h expected %h", d, exp); end
    checks++; if (lat != 2) begin fails++; $display("FAIL misaligned_latency: got %0d expected 2", lat); end
    checks++; if (f1 !== 1'b1) begin fails++; $display("FAIL misaligned_fault_edge: got %b expected 1", f1); end
    exp_q.push_back(32'h0);
    issue_read(32'h0001_0000, d, lat, w, f1, ra, va, vc);
    exp = exp_q.pop_front();
    checks++; if (d !== exp) begin fails++; $display("FAIL range_data: got %h expected %h", d, exp); end
    checks++; if (lat != 2) begin fails++; $display("FAIL range_latency: got %0d expected 2", lat); end
    checks++; if (fault !== 1'b1) begin fails++; $display("FAIL range_fault_sticky: got %b expected 1", fault); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; int lat; int w; logic f1; logic ra; logic va; int vc;
    logic [31:0] exp;
    mem_addr = 32'h8;
    #1;
    checks++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL midrst_accept_ready: got %b expected 1", mem_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", mem_valid); end
    checks++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b expected 1", mem_ready); end
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL midrst_fault: got %b expected 0", fault); end
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL midrst_no_late_valid: got %b expected 0", mem_valid); end
    exp_q.push_back(32'h0020_0113);
    issue_read(32'h8, d, lat, w, f1, ra, va, vc);
    exp = exp_q.pop_front();
    checks++; if (d !== exp) begin fails++; $display("FAIL midrst_data: got %h expected %h", d, exp); end
    checks++; if (lat != 2) begin fails++; $display("FAIL midrst_latency: got %0d expected 2", lat); end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    cyc       = 0;
    rst       = 1'b1;
    mem_addr  = 32'h0;
    load_en   = 1'b0;
    load_addr = 32'h0;
    load_data = 32'h0;
    @(negedge clk);
    test_reset();
    test_first_read();
    test_fetch_loop();
    test_load_hold();
    test_busy_load();
    test_fault();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
